// File: rtl/i2c_sensor_target.sv
// I2C target serving a 16-bit result register (pointer 0) and a 16-bit config register (pointer 1).
// Define I2C_TARGET_TIMEOUT_EN to add an SCL-stuck-low bus timeout.
module i2c_sensor_target #(
  parameter logic [6:0]  TARGET_ADDR    = 7'h48,
  parameter logic [15:0] CFG_RESET      = 16'h0000,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] result_in,
  output logic [15:0] cfg_out,
  output logic        cfg_wr,
  output logic        rd_strobe,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
  } state_t;

  state_t      state, state_n;
  logic        scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  sreg, sreg_n, sreg_shift, tx_sh, tx_sh_n, tx_byte, msb_stage, msb_n;
  logic [15:0] snap, snap_n, sel_word, cfg_n;
  logic [1:0]  pointer, pointer_n;
  logic        byte_idx, byte_idx_n, rx_first, rx_first_n, rx_lsb, rx_lsb_n;
  logic        sda_oe_n, busy_n, cfg_wr_n, rd_strobe_n;
  logic        scl_rise, scl_fall, start_det, stop_det, timeout;

  assign scl_rise   = scl_s2 & ~scl_h;
  assign scl_fall   = ~scl_s2 & scl_h;
  // Requiring SCL high on both the current and history sample rejects SDA moving with SCL.
  assign start_det  = scl_s2 & scl_h & ~sda_s2 & sda_h;
  assign stop_det   = scl_s2 & scl_h & sda_s2 & ~sda_h;
  assign sreg_shift = {sreg[6:0], sda_s2};

  always_comb begin
    case (pointer)
      2'd0:    sel_word = snap;
      2'd1:    sel_word = cfg_out;
      default: sel_word = 16'h0000;
    endcase
    tx_byte = byte_idx ? sel_word[7:0] : sel_word[15:8];
  end

`ifdef I2C_TARGET_TIMEOUT_EN
  logic [19:0] to_cnt;
  always_ff @(posedge clk) begin
    if (rst || scl_s2 || !busy) to_cnt <= 20'd0;
    else                        to_cnt <= to_cnt + 20'd1;
  end
  assign timeout = busy & ~scl_s2 & (to_cnt == TIMEOUT_CYCLES - 20'd1);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    sda_oe_n    = sda_oe;
    bit_cnt_n   = bit_cnt;
    sreg_n      = sreg;
    tx_sh_n     = tx_sh;
    byte_idx_n  = byte_idx;
    busy_n      = busy;
    pointer_n   = pointer;
    cfg_n       = cfg_out;
    msb_n       = msb_stage;
    rx_first_n  = rx_first;
    rx_lsb_n    = rx_lsb;
    snap_n      = snap;
    cfg_wr_n    = 1'b0;
    rd_strobe_n = 1'b0;
    if (timeout) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            sreg_n    = sreg_shift;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (sreg_shift[7:1] == TARGET_ADDR) busy_n = 1'b1;
              else                                state_n = WAIT_STOP;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n    = 1'b1;
            state_n     = ADDR_ACK;
            snap_n      = result_in;
            rd_strobe_n = 1'b1;
            byte_idx_n  = 1'b0;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (sreg[0]) begin
              tx_sh_n   = tx_byte;
              sda_oe_n  = ~tx_byte[7];
              bit_cnt_n = 4'd1;
              state_n   = TX_BYTE;
            end else begin
              sda_oe_n   = 1'b0;
              bit_cnt_n  = 4'd0;
              rx_first_n = 1'b1;
              rx_lsb_n   = 1'b0;
              state_n    = RX_BYTE;
            end
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n = 1'b0;
              state_n  = TX_ACK;
            end else begin
              sda_oe_n  = ~tx_sh[6];
              tx_sh_n   = {tx_sh[6:0], 1'b0};
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        TX_ACK: begin
          // The first event after entry is the ACK rise, so a fall here always follows an ACK.
          if (scl_rise) begin
            if (sda_s2) state_n = WAIT_STOP;
            else        byte_idx_n = ~byte_idx;
          end else if (scl_fall) begin
            tx_sh_n   = tx_byte;
            sda_oe_n  = ~tx_byte[7];
            bit_cnt_n = 4'd1;
            state_n   = TX_BYTE;
          end
        end
        RX_BYTE: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            sreg_n    = sreg_shift;
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n  = 1'b1;
            bit_cnt_n = 4'd0;
            state_n   = RX_ACK;
            if (rx_first) begin
              pointer_n  = sreg[1:0];
              rx_first_n = 1'b0;
            end else if (!rx_lsb) begin
              msb_n    = sreg;
              rx_lsb_n = 1'b1;
            end else begin
              rx_lsb_n = 1'b0;
              if (pointer == 2'd1) begin
                cfg_n    = {msb_stage, sreg};
                cfg_wr_n = 1'b1;
              end
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
            state_n   = RX_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
      state     <= IDLE;
      sda_oe    <= 1'b0;
      bit_cnt   <= 4'd0;
      sreg      <= 8'h00;
      tx_sh     <= 8'h00;
      byte_idx  <= 1'b0;
      busy      <= 1'b0;
      pointer   <= 2'd0;
      cfg_out   <= CFG_RESET;
      msb_stage <= 8'h00;
      rx_first  <= 1'b0;
      rx_lsb    <= 1'b0;
      snap      <= 16'h0000;
      cfg_wr    <= 1'b0;
      rd_strobe <= 1'b0;
    end else begin
      {scl_s1, scl_s2, scl_h} <= {scl, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_h} <= {sda_in, sda_s1, sda_s2};
      state     <= state_n;
      sda_oe    <= sda_oe_n;
      bit_cnt   <= bit_cnt_n;
      sreg      <= sreg_n;
      tx_sh     <= tx_sh_n;
      byte_idx  <= byte_idx_n;
      busy      <= busy_n;
      pointer   <= pointer_n;
      cfg_out   <= cfg_n;
      msb_stage <= msb_n;
      rx_first  <= rx_first_n;
      rx_lsb    <= rx_lsb_n;
      snap      <= snap_n;
      cfg_wr    <= cfg_wr_n;
      rd_strobe <= rd_strobe_n;
    end
  end

endmodule

// File: tb/tb_i2c_sensor_target.sv
// Bench for i2c_sensor_target: bit-banged I2C controller tasks, scoreboard queue, end report.
module tb_i2c_sensor_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe;
  logic [15:0] result_in = 16'h0000;
  logic [15:0] cfg_out;
  logic        cfg_wr, rd_strobe, busy;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_sensor_target #(
    .TARGET_ADDR(7'h48),
    .CFG_RESET(16'h0000),
    .TIMEOUT_CYCLES(20'd100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scl(scl),
    .sda_in(sda_bus),
    .sda_oe(sda_oe),
    .result_in(result_in),
    .cfg_out(cfg_out),
    .cfg_wr(cfg_wr),
    .rd_strobe(rd_strobe),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cfg_wr_cnt = 0;
  int rd_cnt = 0;
  int quiet_viol = 0;
  logic watch_quiet = 1'b0;
  // Entries: [15:8] kind (1 = ack bit, 2 = read byte), [7:0] value.
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [15:0] exp_cfg_q[$];
  logic [15:0] mon_o, mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (obs_q.size() > 0) begin
      mon_o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_obs: got %0h expected none", mon_o);
      end else begin
        mon_e = exp_q.pop_front();
        check((mon_e[15:8] == 8'h01) ? "ack_bit" : "read_byte", mon_o, mon_e);
      end
    end
    if (!rst && cfg_wr) begin
      cfg_wr_cnt++;
      if (exp_cfg_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cfg_wr_unexpected: got %0h expected none", cfg_out);
      end else begin
        check("cfg_value", cfg_out, exp_cfg_q.pop_front());
      end
    end
    if (!rst && rd_strobe) rd_cnt++;
    if (watch_quiet && sda_oe) quiet_viol++;
  end

  task automatic q_wait;
    repeat (5) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; q_wait();
    scl = 1'b1;   q_wait();
    sda_m = 1'b0; q_wait();
    scl = 1'b0;   q_wait();
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; q_wait();
    scl = 1'b1;   q_wait();
    sda_m = 1'b1; q_wait();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; q_wait();
    scl = 1'b1; q_wait(); q_wait();
    scl = 1'b0; q_wait();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; q_wait();
    scl = 1'b1;   q_wait();
    b = sda_bus;  q_wait();
    scl = 1'b0;   q_wait();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack);
    logic a;
    exp_q.push_back({8'h01, 7'b0, exp_ack});
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    obs_q.push_back({8'h01, 7'b0, a});
  endtask

  task automatic read_byte(input logic [7:0] exp_d, input logic ack_bit);
    logic [7:0] d;
    logic b;
    exp_q.push_back({8'h02, exp_d});
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    obs_q.push_back({8'h02, d});
    write_bit(ack_bit);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int rd0, wr0, n;
    logic b;
    // Reset
    repeat (4) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_cfg_out", cfg_out, 16'h0000);
    check("rst_cfg_wr", cfg_wr, 0);
    check("rst_rd_strobe", rd_strobe, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Pointer 0 write, repeated START, two-byte read
    result_in = 16'h1900;
    rd0 = rd_cnt;
    i2c_start();
    write_byte(8'h90, 1'b0);
    check("busy_after_match", busy, 1);
    write_byte(8'h00, 1'b0);
    i2c_start();
    write_byte(8'h91, 1'b0);
    read_byte(8'h19, 1'b0);
    read_byte(8'h00, 1'b1);
    check("sda_released_after_nack", sda_oe, 0);
    i2c_stop();
    check("busy_after_stop", busy, 0);
    check("rd_strobe_per_addr", rd_cnt - rd0, 2);

    // Config write then read back
    wr0 = cfg_wr_cnt;
    exp_cfg_q.push_back(16'hABCD);
    i2c_start();
    write_byte(8'h90, 1'b0);
    write_byte(8'h01, 1'b0);
    write_byte(8'hAB, 1'b0);
    write_byte(8'hCD, 1'b0);
    i2c_stop();
    check("cfg_out_written", cfg_out, 16'hABCD);
    check("cfg_wr_pulses", cfg_wr_cnt - wr0, 1);
    i2c_start();
    write_byte(8'h91, 1'b0);
    read_byte(8'hAB, 1'b0);
    read_byte(8'hCD, 1'b1);
    i2c_stop();

    // Wrong address: never drives SDA
    quiet_viol = 0;
    watch_quiet = 1'b1;
    i2c_start();
    write_byte(8'h93, 1'b1);
    check("busy_wrong_addr", busy, 0);
    i2c_stop();
    watch_quiet = 1'b0;
    check("no_drive_wrong_addr", quiet_viol, 0);
    check("cfg_kept_wrong_addr", cfg_out, 16'hABCD);

    // Snapshot prevents tearing
    result_in = 16'h1900;
    i2c_start();
    write_byte(8'h90, 1'b0);
    write_byte(8'h00, 1'b0);
    i2c_start();
    write_byte(8'h91, 1'b0);
    read_byte(8'h19, 1'b0);
    result_in = 16'h7FF0;
    read_byte(8'h00, 1'b1);
    i2c_stop();
    i2c_start();
    write_byte(8'h91, 1'b0);
    read_byte(8'h7F, 1'b0);
    read_byte(8'hF0, 1'b1);
    i2c_stop();

    // Reset while driving a 0 data bit
    result_in = 16'h1900;
    i2c_start();
    write_byte(8'h91, 1'b0);
    check("tx_drives_zero", sda_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx_sda_oe", sda_oe, 0);
    check("rst_mid_tx_cfg", cfg_out, 16'h0000);
    check("rst_mid_tx_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    i2c_stop();
    i2c_start();
    write_byte(8'h91, 1'b0);
    read_byte(8'h19, 1'b0);
    read_byte(8'h00, 1'b1);
    i2c_stop();
    exp_cfg_q.push_back(16'h55AA);
    i2c_start();
    write_byte(8'h90, 1'b0);
    write_byte(8'h01, 1'b0);
    write_byte(8'h55, 1'b0);
    write_byte(8'hAA, 1'b0);
    i2c_stop();
    check("cfg_after_reset_write", cfg_out, 16'h55AA);

`ifdef I2C_TARGET_TIMEOUT_EN
    // SCL held low mid-read
    exp_cfg_q.push_back(16'h1234);
    i2c_start();
    write_byte(8'h90, 1'b0);
    write_byte(8'h01, 1'b0);
    write_byte(8'h12, 1'b0);
    write_byte(8'h34, 1'b0);
    i2c_stop();
    i2c_start();
    write_byte(8'h91, 1'b0);
    read_byte(8'h12, 1'b0);
    read_bit(b);
    check("timeout_first_bit", b, 0);
    check("timeout_pre_drive", sda_oe, 1);
    n = 0;
    while (busy && n < 150) begin
      @(negedge clk);
      n++;
    end
    check("timeout_busy", busy, 0);
    check("timeout_window", (n >= 90 && n <= 100), 1);
    check("timeout_sda_released", sda_oe, 0);
    repeat (150 - n) @(negedge clk);
    i2c_stop();
    i2c_start();
    write_byte(8'h91, 1'b0);
    read_byte(8'h12, 1'b0);
    read_byte(8'h34, 1'b1);
    i2c_stop();
    check("timeout_cfg_kept", cfg_out, 16'h1234);
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("cfg_queue_drained", exp_cfg_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
